instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Inverse of the instruction decode stage: accepts symbolic RV32I/M instruction requests (op + rd/rs1/rs2 + imm),
//  encodes them into 32-bit instruction words and writes them sequentially into instruction memory.
//  Used by the boot/self-test sequencer to build programs in IMEM before the core is released from reset.
//  Registered, one-word-per-cycle throughput with valid/ready backpressure on both sides.
// PARAMETERS
//  BASE_ADDR  32'h0000_0000  byte address of first word written after reset/CLEAR
//  DEPTH      1024           max words writable before FULL (power of two not required)
// PORTS
//  CLK          in   1   clock, all state on posedge
//  RSTN         in   1   reset, asynchronous, active-low
//  CLEAR        in   1   sync: flush output reg, address <- BASE_ADDR, FULL/ERR_STICKY <- 0
//  REQ_VALID    in   1   request present
//  REQ_READY    out  1   request accepted when REQ_VALID & REQ_READY at posedge
//  REQ_OP       in   6   inst_op_t (lui..remu, mret), from package
//  REQ_RD/RS1/RS2 in 5   register fields; ignored when op's format lacks them
//  REQ_IMM      in   32  immediate as signed byte offset / value (U-type: full value, low 12 bits must be 0)
//  MEM_WE       out  1   write valid (held until MEM_READY)
//  MEM_READY    in   1   memory accepts write when MEM_WE & MEM_READY
//  MEM_ADDR     out  32  byte address, word-aligned
//  MEM_WDATA    out  32  encoded instruction
//  FULL         out  1   DEPTH words written
//  ERR_ILLEGAL  out  1   1-cycle pulse: last accepted request unencodable
//  ERR_STICKY   out  1   set by ERR_ILLEGAL, cleared by reset/CLEAR
//  WORD_COUNT   out  $clog2(DEPTH+1)  words committed to memory
// BEHAVIOUR
//  Reset: MEM_WE=0, MEM_ADDR=BASE_ADDR, MEM_WDATA=0, FULL=0, ERR_ILLEGAL=0, ERR_STICKY=0, WORD_COUNT=0.
//  REQ_READY = !CLEAR & !FULL & (!MEM_WE | MEM_READY) & (WORD_COUNT + MEM_WE < DEPTH).
//  Latency: request accepted at edge N -> MEM_WE=1 with encoded word from cycle after N; back-to-back with MEM_READY=1.
//  MEM_WE/MEM_ADDR/MEM_WDATA stable while MEM_WE & !MEM_READY.
//  Memory handshake: MEM_ADDR += 4, WORD_COUNT += 1; FULL set when WORD_COUNT reaches DEPTH; no wrap, no further writes.
//  Encoding per ISA: R(funct7|rs2|rs1|f3|rd|op), I, S, B (imm[12|10:5],[4:1|11]), U, J (imm[20|10:1|11|19:12]);
//   shifts: shamt=REQ_IMM[4:0], funct7 0000000 / 0100000 (srai); M-ext funct7 0000001; mret = 32'h3020_0073.
//  Illegal (request consumed, no write, ERR_ILLEGAL next cycle, address unchanged):
//   I/S imm outside [-2048,2047]; B imm odd or outside [-4096,4094]; J imm odd or outside [-2^20,2^20-2];
//   U imm[11:0]!=0; shift imm outside [0,31]; undefined REQ_OP code.
//  CLEAR: priority over everything same cycle; pending MEM_WE word dropped, no request accepted.
//  Reset mid-write: word dropped, state to reset values asynchronously.
// STRUCTURE
//  Shared package (def.sv): inst_op_t enum, opcode/funct3/funct7 localparams, MRET_WORD constant.
//  Sub-module instr_encode_comb: purely combinational {op,fields,imm} -> {word, illegal}; top holds
//  the output register, address/count, FULL, error flags.
// TESTING
//  addi x1,x0,5 @BASE 0 -> MEM_WDATA 32'h0050_0093, MEM_ADDR 0, one cycle after accept.
//  add x3,x1,x2; sw x2,8(x1); beq x1,x2,-4 back-to-back -> 002081B3, 0020A423, FE208EE3 at addr 0,4,8.
//  lui x5,0x12345000; jal x1,2048 -> 123452B7, 001000EF; mret -> 30200073.
//  MEM_READY=0 for 3 cycles -> MEM_WE/ADDR/WDATA stable, REQ_READY=0; resumes, no word lost/duplicated.
//  addi imm=2048, beq imm=3 -> ERR_ILLEGAL pulse each, ERR_STICKY=1, no MEM_WE, address unchanged.
//  DEPTH=4: 5 requests -> 4 writes, FULL=1, REQ_READY=0; CLEAR -> addr BASE, FULL=0, count 0.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I/M instruction encoder: symbolic op codes,
// major opcodes, funct fields and the per-op format lookup.
package instr_encoder_pkg;

  typedef enum logic [5:0] {
    OP_LUI = 6'd0, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_MRET
  } inst_op_t;

  typedef enum logic [3:0] {
    FMT_R = 4'd0, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SYS, FMT_BAD
  } fmt_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [31:0] MRET_WORD = 32'h3020_0073;

  typedef struct packed {
    fmt_t       fmt;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
  } op_info_t;

  function automatic op_info_t op_info(input logic [5:0] op);
    op_info_t info;
    info = '{FMT_BAD, 7'd0, 3'd0, F7_BASE};
    case (op)
      OP_LUI:    info = '{FMT_U,   OPC_LUI,    3'd0, F7_BASE};
      OP_AUIPC:  info = '{FMT_U,   OPC_AUIPC,  3'd0, F7_BASE};
      OP_JAL:    info = '{FMT_J,   OPC_JAL,    3'd0, F7_BASE};
      OP_JALR:   info = '{FMT_I,   OPC_JALR,   3'd0, F7_BASE};
      OP_BEQ:    info = '{FMT_B,   OPC_BRANCH, 3'd0, F7_BASE};
      OP_BNE:    info = '{FMT_B,   OPC_BRANCH, 3'd1, F7_BASE};
      OP_BLT:    info = '{FMT_B,   OPC_BRANCH, 3'd4, F7_BASE};
      OP_BGE:    info = '{FMT_B,   OPC_BRANCH, 3'd5, F7_BASE};
      OP_BLTU:   info = '{FMT_B,   OPC_BRANCH, 3'd6, F7_BASE};
      OP_BGEU:   info = '{FMT_B,   OPC_BRANCH, 3'd7, F7_BASE};
      OP_LB:     info = '{FMT_I,   OPC_LOAD,   3'd0, F7_BASE};
      OP_LH:     info = '{FMT_I,   OPC_LOAD,   3'd1, F7_BASE};
      OP_LW:     info = '{FMT_I,   OPC_LOAD,   3'd2, F7_BASE};
      OP_LBU:    info = '{FMT_I,   OPC_LOAD,   3'd4, F7_BASE};
      OP_LHU:    info = '{FMT_I,   OPC_LOAD,   3'd5, F7_BASE};
      OP_SB:     info = '{FMT_S,   OPC_STORE,  3'd0, F7_BASE};
      OP_SH:     info = '{FMT_S,   OPC_STORE,  3'd1, F7_BASE};
      OP_SW:     info = '{FMT_S,   OPC_STORE,  3'd2, F7_BASE};
      OP_ADDI:   info = '{FMT_I,   OPC_OPIMM,  3'd0, F7_BASE};
      OP_SLTI:   info = '{FMT_I,   OPC_OPIMM,  3'd2, F7_BASE};
      OP_SLTIU:  info = '{FMT_I,   OPC_OPIMM,  3'd3, F7_BASE};
      OP_XORI:   info = '{FMT_I,   OPC_OPIMM,  3'd4, F7_BASE};
      OP_ORI:    info = '{FMT_I,   OPC_OPIMM,  3'd6, F7_BASE};
      OP_ANDI:   info = '{FMT_I,   OPC_OPIMM,  3'd7, F7_BASE};
      OP_SLLI:   info = '{FMT_SH,  OPC_OPIMM,  3'd1, F7_BASE};
      OP_SRLI:   info = '{FMT_SH,  OPC_OPIMM,  3'd5, F7_BASE};
      OP_SRAI:   info = '{FMT_SH,  OPC_OPIMM,  3'd5, F7_ALT};
      OP_ADD:    info = '{FMT_R,   OPC_OP,     3'd0, F7_BASE};
      OP_SUB:    info = '{FMT_R,   OPC_OP,     3'd0, F7_ALT};
      OP_SLL:    info = '{FMT_R,   OPC_OP,     3'd1, F7_BASE};
      OP_SLT:    info = '{FMT_R,   OPC_OP,     3'd2, F7_BASE};
      OP_SLTU:   info = '{FMT_R,   OPC_OP,     3'd3, F7_BASE};
      OP_XOR:    info = '{FMT_R,   OPC_OP,     3'd4, F7_BASE};
      OP_SRL:    info = '{FMT_R,   OPC_OP,     3'd5, F7_BASE};
      OP_SRA:    info = '{FMT_R,   OPC_OP,     3'd5, F7_ALT};
      OP_OR:     info = '{FMT_R,   OPC_OP,     3'd6, F7_BASE};
      OP_AND:    info = '{FMT_R,   OPC_OP,     3'd7, F7_BASE};
      OP_MUL:    info = '{FMT_R,   OPC_OP,     3'd0, F7_MULDIV};
      OP_MULH:   info = '{FMT_R,   OPC_OP,     3'd1, F7_MULDIV};
      OP_MULHSU: info = '{FMT_R,   OPC_OP,     3'd2, F7_MULDIV};
      OP_MULHU:  info = '{FMT_R,   OPC_OP,     3'd3, F7_MULDIV};
      OP_DIV:    info = '{FMT_R,   OPC_OP,     3'd4, F7_MULDIV};
      OP_DIVU:   info = '{FMT_R,   OPC_OP,     3'd5, F7_MULDIV};
      OP_REM:    info = '{FMT_R,   OPC_OP,     3'd6, F7_MULDIV};
      OP_REMU:   info = '{FMT_R,   OPC_OP,     3'd7, F7_MULDIV};
      OP_MRET:   info = '{FMT_SYS, 7'd0,       3'd0, F7_BASE};
      default:   info = '{FMT_BAD, 7'd0,       3'd0, F7_BASE};
    endcase
    return info;
  endfunction

endpackage

// File: rtl/instr_encoder_comb.sv
// Purely combinational encoder: symbolic op + fields + immediate -> 32-bit
// instruction word, flagging immediates that the op's format cannot carry.
module instr_encode_comb
  import instr_encoder_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  op_info_t info_s;

  assign info_s = op_info(op);

  // Assemble the word by format; range checks test that the dropped upper bits are pure sign extension
  always_comb begin
    word    = 32'd0;
    illegal = 1'b0;
    case (info_s.fmt)
      FMT_R: begin
        word = {info_s.f7, rs2, rs1, info_s.f3, rd, info_s.opc};
      end
      FMT_I: begin
        word    = {imm[11:0], rs1, info_s.f3, rd, info_s.opc};
        illegal = (imm[31:11] != {21{imm[11]}});
      end
      FMT_SH: begin
        word    = {info_s.f7, imm[4:0], rs1, info_s.f3, rd, info_s.opc};
        illegal = (imm[31:5] != 27'd0);
      end
      FMT_S: begin
        word    = {imm[11:5], rs2, rs1, info_s.f3, imm[4:0], info_s.opc};
        illegal = (imm[31:11] != {21{imm[11]}});
      end
      FMT_B: begin
        word    = {imm[12], imm[10:5], rs2, rs1, info_s.f3, imm[4:1], imm[11], info_s.opc};
        illegal = imm[0] | (imm[31:12] != {20{imm[12]}});
      end
      FMT_U: begin
        word    = {imm[31:12], rd, info_s.opc};
        illegal = (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, info_s.opc};
        illegal = imm[0] | (imm[31:20] != {12{imm[20]}});
      end
      FMT_SYS: begin
        word = MRET_WORD;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes symbolic instruction requests and streams the words into IMEM,
// one per cycle, with valid/ready on the request side and we/ready on memory.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 1024,
  localparam int         CW        = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          CLEAR,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic [5:0]    REQ_OP,
  input  logic [4:0]    REQ_RD,
  input  logic [4:0]    REQ_RS1,
  input  logic [4:0]    REQ_RS2,
  input  logic [31:0]   REQ_IMM,
  output logic          MEM_WE,
  input  logic          MEM_READY,
  output logic [31:0]   MEM_ADDR,
  output logic [31:0]   MEM_WDATA,
  output logic          FULL,
  output logic          ERR_ILLEGAL,
  output logic          ERR_STICKY,
  output logic [CW-1:0] WORD_COUNT
);

  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic          mem_we_r;
  logic [31:0]   mem_addr_r;
  logic [31:0]   mem_wdata_r;
  logic          full_r;
  logic          err_illegal_r;
  logic          err_sticky_r;
  logic [CW-1:0] word_count_r;

  logic [31:0]   enc_word_s;
  logic          enc_illegal_s;
  logic [CW:0]   pending_s;
  logic          req_ready_s;
  logic          accept_s;
  logic          mem_fire_s;

  instr_encode_comb u_enc (
    .op      (REQ_OP),
    .rd      (REQ_RD),
    .rs1     (REQ_RS1),
    .rs2     (REQ_RS2),
    .imm     (REQ_IMM),
    .word    (enc_word_s),
    .illegal (enc_illegal_s)
  );

  // Committed words plus the one in flight must leave room for the next request
  assign pending_s   = {1'b0, word_count_r} + {{CW{1'b0}}, mem_we_r};
  assign req_ready_s = !CLEAR && !full_r && (!mem_we_r || MEM_READY) && (pending_s < DEPTH_W);
  assign accept_s    = REQ_VALID && req_ready_s;
  assign mem_fire_s  = mem_we_r && MEM_READY;

  // Output word register: loads on a legal accept, drops after the memory takes it
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      mem_we_r    <= 1'b0;
      mem_wdata_r <= 32'd0;
    end else if (CLEAR) begin
      mem_we_r    <= 1'b0;
      mem_wdata_r <= 32'd0;
    end else if (accept_s && !enc_illegal_s) begin
      mem_we_r    <= 1'b1;
      mem_wdata_r <= enc_word_s;
    end else if (mem_fire_s) begin
      mem_we_r    <= 1'b0;
    end else begin
      mem_we_r    <= mem_we_r;
    end
  end

  // Address, count, FULL and error flags
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      mem_addr_r    <= BASE_ADDR;
      word_count_r  <= {CW{1'b0}};
      full_r        <= 1'b0;
      err_illegal_r <= 1'b0;
      err_sticky_r  <= 1'b0;
    end else if (CLEAR) begin
      mem_addr_r    <= BASE_ADDR;
      word_count_r  <= {CW{1'b0}};
      full_r        <= 1'b0;
      err_illegal_r <= 1'b0;
      err_sticky_r  <= 1'b0;
    end else begin
      err_illegal_r <= accept_s && enc_illegal_s;
      err_sticky_r  <= err_sticky_r || (accept_s && enc_illegal_s);
      if (mem_fire_s) begin
        mem_addr_r   <= mem_addr_r + 32'd4;
        word_count_r <= word_count_r + CW'(1'b1);
        // pending_s already counts the word being committed now
        full_r       <= (pending_s == DEPTH_W);
      end else begin
        mem_addr_r   <= mem_addr_r;
        word_count_r <= word_count_r;
        full_r       <= full_r;
      end
    end
  end

  assign REQ_READY   = req_ready_s;
  assign MEM_WE      = mem_we_r;
  assign MEM_ADDR    = mem_addr_r;
  assign MEM_WDATA   = mem_wdata_r;
  assign FULL        = full_r;
  assign ERR_ILLEGAL = err_illegal_r;
  assign ERR_STICKY  = err_sticky_r;
  assign WORD_COUNT  = word_count_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed ISA vectors plus randomized traffic checked
// every cycle against a behavioural model of the encoder and its handshakes.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 4;

  logic        CLK, RSTN, CLEAR, REQ_VALID, REQ_READY, MEM_WE, MEM_READY;
  logic [5:0]  REQ_OP;
  logic [4:0]  REQ_RD, REQ_RS1, REQ_RS2;
  logic [31:0] REQ_IMM, MEM_ADDR, MEM_WDATA;
  logic        FULL, ERR_ILLEGAL, ERR_STICKY;
  logic [2:0]  WORD_COUNT;

  int n_checks = 0;
  int n_errors = 0;

  // model state: what the outputs must show after the most recent edge
  bit          m_pend, m_full, m_err, m_sticky;
  logic [31:0] m_addr, m_word;
  int          m_count;

  instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RSTN(RSTN), .CLEAR(CLEAR),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
    .REQ_RD(REQ_RD), .REQ_RS1(REQ_RS1), .REQ_RS2(REQ_RS2), .REQ_IMM(REQ_IMM),
    .MEM_WE(MEM_WE), .MEM_READY(MEM_READY), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .FULL(FULL), .ERR_ILLEGAL(ERR_ILLEGAL), .ERR_STICKY(ERR_STICKY), .WORD_COUNT(WORD_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference encoder driven by the ISA tables, indexed by position in the op list
  function automatic void ref_encode(input int op, input logic [4:0] rd, rs1, rs2,
                                     input logic [31:0] imm, output logic [31:0] w, output bit bad);
    int br_f3[6]  = '{0, 1, 4, 5, 6, 7};
    int ld_f3[5]  = '{0, 1, 2, 4, 5};
    int ai_f3[6]  = '{0, 2, 3, 4, 6, 7};
    int rr_f3[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    int v;
    logic [31:0] u;
    logic [2:0]  f3;
    logic [6:0]  f7, opc;
    bit i_bad;
    v = imm; u = imm; w = 0; bad = 0; f7 = 0; f3 = 0;
    i_bad = (v < -2048) || (v > 2047);
    if (op <= 1) begin
      bad = (u[11:0] != 0);
      w = {u[31:12], rd, (op == 0) ? 7'h37 : 7'h17};
    end else if (op == 2) begin
      bad = (v % 2 != 0) || (v < -1048576) || (v > 1048574);
      w = {u[20], u[10:1], u[11], u[19:12], rd, 7'h6F};
    end else if (op == 3 || (op >= 10 && op <= 14) || (op >= 18 && op <= 23)) begin
      opc = (op == 3) ? 7'h67 : (op <= 14) ? 7'h03 : 7'h13;
      f3 = (op == 3) ? 3'd0 : (op <= 14) ? 3'(ld_f3[op-10]) : 3'(ai_f3[op-18]);
      bad = i_bad;
      w = {u[11:0], rs1, f3, rd, opc};
    end else if (op >= 4 && op <= 9) begin
      f3 = 3'(br_f3[op-4]);
      bad = (v % 2 != 0) || (v < -4096) || (v > 4094);
      w = {u[12], u[10:5], rs2, rs1, f3, u[4:1], u[11], 7'h63};
    end else if (op >= 15 && op <= 17) begin
      f3 = 3'(op - 15);
      bad = i_bad;
      w = {u[11:5], rs2, rs1, f3, u[4:0], 7'h23};
    end else if (op >= 24 && op <= 26) begin
      f3 = (op == 24) ? 3'd1 : 3'd5;
      f7 = (op == 26) ? 7'h20 : 7'h00;
      bad = (v < 0) || (v > 31);
      w = {f7, u[4:0], rs1, f3, rd, 7'h13};
    end else if (op >= 27 && op <= 44) begin
      f3 = (op <= 36) ? 3'(rr_f3[op-27]) : 3'(op - 37);
      f7 = (op >= 37) ? 7'h01 : (op == 28 || op == 34) ? 7'h20 : 7'h00;
      w = {f7, rs2, rs1, f3, rd, 7'h33};
    end else if (op == 45) begin
      w = 32'h3020_0073;
    end else begin
      bad = 1;
    end
  endfunction

  function automatic logic [31:0] rand_imm();
    int edges[14] = '{2047, -2048, 2048, -2049, 4094, -4096, 4096, -4098, 31, 32, -1,
                      1048574, -1048576, 1048576};
    int v;
    case ($urandom_range(6))
      0: v = int'($urandom_range(4200)) - 2100;
      1: v = int'($urandom_range(8400)) - 4200;
      2: v = int'($urandom_range(2200000)) - 1100000;
      3: v = int'($urandom & 32'hFFFF_F000);
      4: v = int'($urandom_range(40));
      5: v = int'($urandom);
      default: v = edges[$urandom_range(13)];
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_full = 0; m_err = 0; m_sticky = 0;
    m_addr = BASE; m_word = 0; m_count = 0;
  endtask

  // One clock: check all outputs mid-cycle, advance the model, return #1 after the edge
  task automatic cycle();
    bit exp_ready, fire, bad;
    logic [31:0] w;
    @(negedge CLK);
    exp_ready = !CLEAR && !m_full && (!m_pend || MEM_READY) && (m_count + int'(m_pend) < DEPTH);
    chk("req_ready", {31'd0, REQ_READY}, {31'd0, exp_ready});
    chk("mem_we", {31'd0, MEM_WE}, {31'd0, m_pend});
    chk("mem_addr", MEM_ADDR, m_addr);
    if (m_pend) chk("mem_wdata", MEM_WDATA, m_word);
    chk("full", {31'd0, FULL}, {31'd0, m_full});
    chk("err_illegal", {31'd0, ERR_ILLEGAL}, {31'd0, m_err});
    chk("err_sticky", {31'd0, ERR_STICKY}, {31'd0, m_sticky});
    chk("word_count", 32'(WORD_COUNT), m_count);
    if (CLEAR) begin
      model_reset();
    end else begin
      fire = m_pend && MEM_READY;
      m_err = 0;
      if (fire) begin
        m_addr += 4; m_count++; m_pend = 0;
        if (m_count == DEPTH) m_full = 1;
      end
      if (REQ_VALID && exp_ready) begin
        ref_encode(int'(REQ_OP), REQ_RD, REQ_RS1, REQ_RS2, REQ_IMM, w, bad);
        if (bad) begin m_err = 1; m_sticky = 1; end
        else begin m_pend = 1; m_word = w; end
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic req(input logic [5:0] op, input int rd, rs1, rs2, input logic [31:0] imm);
    REQ_OP = op; REQ_RD = 5'(rd); REQ_RS1 = 5'(rs1); REQ_RS2 = 5'(rs2); REQ_IMM = imm;
    REQ_VALID = 1'b1;
  endtask

  task automatic do_clear();
    CLEAR = 1'b1; REQ_VALID = 1'b1;
    cycle();
    CLEAR = 1'b0; REQ_VALID = 1'b0;
  endtask

  initial begin
    RSTN = 1'b0; CLEAR = 1'b0; REQ_VALID = 1'b0; MEM_READY = 1'b1;
    REQ_OP = 6'd0; REQ_RD = 5'd0; REQ_RS1 = 5'd0; REQ_RS2 = 5'd0; REQ_IMM = 32'd0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_we", {31'd0, MEM_WE}, 32'd0);
    chk("rst_addr", MEM_ADDR, BASE);
    chk("rst_wdata", MEM_WDATA, 32'd0);
    chk("rst_full", {31'd0, FULL}, 32'd0);
    chk("rst_err", {31'd0, ERR_ILLEGAL}, 32'd0);
    chk("rst_sticky", {31'd0, ERR_STICKY}, 32'd0);
    chk("rst_count", 32'(WORD_COUNT), 32'd0);
    RSTN = 1'b1;

    // addi x1,x0,5
    req(OP_ADDI, 1, 0, 0, 32'd5); cycle(); REQ_VALID = 1'b0;
    chk("addi_we", {31'd0, MEM_WE}, 32'd1);
    chk("addi_word", MEM_WDATA, 32'h0050_0093);
    chk("addi_addr", MEM_ADDR, BASE);
    cycle(); do_clear();

    // add / sw / beq back-to-back
    req(OP_ADD, 3, 1, 2, 32'd0); cycle();
    chk("add_word", MEM_WDATA, 32'h0020_81B3); chk("add_addr", MEM_ADDR, BASE);
    req(OP_SW, 0, 1, 2, 32'd8); cycle();
    chk("sw_word", MEM_WDATA, 32'h0020_A423); chk("sw_addr", MEM_ADDR, BASE + 32'd4);
    req(OP_BEQ, 0, 1, 2, 32'hFFFF_FFFC); cycle();
    chk("beq_word", MEM_WDATA, 32'hFE20_8EE3); chk("beq_addr", MEM_ADDR, BASE + 32'd8);
    REQ_VALID = 1'b0; cycle(); do_clear();

    // lui / jal / mret
    req(OP_LUI, 5, 0, 0, 32'h1234_5000); cycle(); chk("lui_word", MEM_WDATA, 32'h1234_52B7);
    req(OP_JAL, 1, 0, 0, 32'd2048); cycle(); chk("jal_word", MEM_WDATA, 32'h0010_00EF);
    req(OP_MRET, 0, 0, 0, 32'd0); cycle(); chk("mret_word", MEM_WDATA, 32'h3020_0073);
    REQ_VALID = 1'b0; cycle(); do_clear();

    // memory stall for 3 cycles
    MEM_READY = 1'b0;
    req(OP_ADDI, 1, 0, 0, 32'd5); cycle();
    req(OP_ADD, 3, 1, 2, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_we", {31'd0, MEM_WE}, 32'd1);
      chk("stall_word", MEM_WDATA, 32'h0050_0093);
      chk("stall_addr", MEM_ADDR, BASE);
      chk("stall_ready", {31'd0, REQ_READY}, 32'd0);
    end
    MEM_READY = 1'b1; cycle();
    chk("resume_word", MEM_WDATA, 32'h0020_81B3); chk("resume_addr", MEM_ADDR, BASE + 32'd4);
    REQ_VALID = 1'b0; cycle();
    chk("resume_count", 32'(WORD_COUNT), 32'd2);
    do_clear();

    // illegal immediates
    req(OP_ADDI, 1, 0, 0, 32'd2048); cycle();
    chk("ill_addi_err", {31'd0, ERR_ILLEGAL}, 32'd1);
    chk("ill_addi_we", {31'd0, MEM_WE}, 32'd0);
    req(OP_BEQ, 0, 1, 2, 32'd3); cycle();
    chk("ill_beq_err", {31'd0, ERR_ILLEGAL}, 32'd1);
    chk("ill_beq_we", {31'd0, MEM_WE}, 32'd0);
    REQ_VALID = 1'b0; cycle();
    chk("ill_pulse_end", {31'd0, ERR_ILLEGAL}, 32'd0);
    chk("ill_sticky", {31'd0, ERR_STICKY}, 32'd1);
    chk("ill_addr", MEM_ADDR, BASE);
    do_clear();

    // fill to DEPTH
    req(OP_ADDI, 1, 0, 0, 32'd5);
    repeat (7) cycle();
    chk("full_flag", {31'd0, FULL}, 32'd1);
    chk("full_count", 32'(WORD_COUNT), DEPTH);
    chk("full_ready", {31'd0, REQ_READY}, 32'd0);
    chk("full_addr", MEM_ADDR, BASE + 32'd16);
    do_clear();
    chk("clr_addr", MEM_ADDR, BASE);
    chk("clr_full", {31'd0, FULL}, 32'd0);
    chk("clr_count", 32'(WORD_COUNT), 32'd0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      REQ_VALID = ($urandom_range(3) != 0);
      REQ_OP = ($urandom_range(9) == 0) ? 6'($urandom_range(63, 46)) : 6'($urandom_range(45));
      REQ_RD = 5'($urandom); REQ_RS1 = 5'($urandom); REQ_RS2 = 5'($urandom);
      REQ_IMM = rand_imm();
      MEM_READY = ($urandom_range(9) < 7);
      CLEAR = (m_full && $urandom_range(2) == 0) || ($urandom_range(49) == 0);
      cycle();
    end
    CLEAR = 1'b0; REQ_VALID = 1'b0; MEM_READY = 1'b1;
    cycle();

    // reset while a write is pending
    MEM_READY = 1'b0;
    req(OP_ADDI, 1, 0, 0, 32'd5); cycle(); REQ_VALID = 1'b0;
    #1 RSTN = 1'b0;
    #1;
    chk("rstmid_we", {31'd0, MEM_WE}, 32'd0);
    chk("rstmid_addr", MEM_ADDR, BASE);
    chk("rstmid_count", 32'(WORD_COUNT), 32'd0);
    @(posedge CLK); #1;
    RSTN = 1'b1; MEM_READY = 1'b1;
    model_reset();
    repeat (2) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
